// File: rtl/block_fill_responder.sv
// Memory-side responder for cache line fills: returns the 8 words of a 16-byte
// block as a fixed-latency burst, and accepts single-word stores while idle.
module block_fill_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] req_addr,
  input  logic        wr,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic [15:0] data_out,
  output logic [15:0] data_addr,
  output logic        data_valid,
  output logic        done
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  lat_q, lat_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] daddr_q, daddr_d;

  logic [15:0] mem [MEM_WORDS];
  logic [2:0]  rd_i;
  logic        mem_we;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[3:0], wr_addr[0]};

  function automatic logic [AW-1:0] widx(input logic [14:0] w);
    return AW'(32'(w) % MEM_WORDS);
  endfunction

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    dout_d  = dout_q;
    daddr_d = daddr_q;
    rd_i    = cnt_q + 3'd1;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we = wr;
        if (req) begin
          base_d  = req_addr[15:4];
          cnt_d   = 3'd0;
          lat_d   = 4'(LATENCY - 2);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Word 0 is launched on the last WAIT edge so it is visible LATENCY
        // cycles after the accept edge.
        if (lat_q == 4'd0) begin
          rd_i    = 3'd0;
          cnt_d   = 3'd0;
          vld_d   = 1'b1;
          state_d = S_BURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_BURST: begin
        if (cnt_q == 3'd7) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d  = rd_i;
          vld_d  = 1'b1;
          done_d = (rd_i == 3'd7);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Storage is read at presentation time; writes cannot occur outside IDLE.
    if (vld_d) begin
      dout_d  = mem[widx({base_q, rd_i})];
      daddr_d = {base_q, rd_i, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      lat_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      daddr_q <= daddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[widx(wr_addr[15:1])] <= wr_data;
  end

  assign busy       = busy_q;
  assign data_valid = vld_q;
  assign done       = done_q;
  assign data_out   = dout_q;
  assign data_addr  = daddr_q;

endmodule
